// File: rtl/ddr_line_reader_if.sv
// Signal bundle between the line reader, its AXI4 read slave, the video controller and the
// line FIFO. The master modport is the reader's view; slave is everything around it.
interface ddr_line_reader_if #(
    parameter int unsigned AXI4_DATA_WIDTH = 128,
    parameter int unsigned AXI4_ADDR_WIDTH = 32
);
    logic                       AXI_FULL_BURST_VALID;
    logic                       AXI_FULL_BURST_READY;
    logic                       frame_start;
    logic [AXI4_ADDR_WIDTH-1:0] frame_base;
    logic [AXI4_ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]                 M_AXI_ARLEN;
    logic [2:0]                 M_AXI_ARSIZE;
    logic [1:0]                 M_AXI_ARBURST;
    logic                       M_AXI_ARVALID;
    logic                       M_AXI_ARREADY;
    logic [AXI4_DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]                 M_AXI_RRESP;
    logic                       M_AXI_RLAST;
    logic                       M_AXI_RVALID;
    logic                       M_AXI_RREADY;
    logic                       fifo_wr_en;
    logic [AXI4_DATA_WIDTH-1:0] fifo_wr_data;
    logic                       fifo_prog_full;
    logic                       rd_err;

    modport master (
        input  AXI_FULL_BURST_VALID, frame_start, frame_base,
        output AXI_FULL_BURST_READY,
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY,
        output fifo_wr_en, fifo_wr_data,
        input  fifo_prog_full,
        output rd_err
    );

    modport slave (
        output AXI_FULL_BURST_VALID, frame_start, frame_base,
        input  AXI_FULL_BURST_READY,
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  fifo_wr_en, fifo_wr_data,
        output fifo_prog_full,
        input  rd_err
    );
endinterface

// File: rtl/ddr_line_reader.sv
// Frame-buffer read master: fetches one display line per request as a sequence of single
// outstanding AXI4 INCR bursts and forwards every beat to the video line FIFO.
module ddr_line_reader #(
    parameter int unsigned AXI4_DATA_WIDTH = 128,
    parameter int unsigned AXI4_ADDR_WIDTH = 32,
    parameter int unsigned H_DISP          = 1920,
    parameter int unsigned V_DISP          = 1080,
    parameter int unsigned BURST_LEN       = 16
) (
    input logic                M_AXI_ACLK,
    input logic                M_AXI_ARESET,
    ddr_line_reader_if.master  bus
);
    localparam int unsigned BEAT_BYTES  = AXI4_DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned LINE_BYTES  = H_DISP * 4;
    localparam int unsigned BURSTS      = LINE_BYTES / BURST_BYTES;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BURST_W     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int unsigned LINE_W      = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int unsigned AW          = AXI4_ADDR_WIDTH;

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(BURSTS - 1);
    localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(V_DISP - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StGap} state_e;

    state_e                     r_state, w_state_nxt;
    logic                       r_ready, w_ready_nxt;
    logic                       r_arvalid, w_arvalid_nxt;
    logic [AW-1:0]              r_araddr, w_araddr_nxt;
    logic                       r_wr_en, w_wr_en_nxt;
    logic [AXI4_DATA_WIDTH-1:0] r_wr_data, w_wr_data_nxt;
    logic                       r_err, w_err_nxt;
    logic [LINE_W-1:0]          r_line_idx, w_line_idx_nxt;
    logic [AW-1:0]              r_base, w_base_nxt;
    logic [BURST_W-1:0]         r_burst_cnt, w_burst_cnt_nxt;
    logic [BEAT_W-1:0]          r_beat_cnt, w_beat_cnt_nxt;
    logic                       r_fs_pend, w_fs_pend_nxt;

    logic                       w_req;
    logic                       w_beat;
    logic                       w_last_beat;
    logic                       w_beat_err;
    logic [LINE_W-1:0]          w_req_idx;
    logic [AW-1:0]              w_frame_base;
    logic [AW-1:0]              w_req_base;
    logic [AW-1:0]              w_line_off;
    logic                       w_unused;

    assign w_req        = r_ready && bus.AXI_FULL_BURST_VALID;
    assign w_beat       = (r_state == StData) && bus.M_AXI_RVALID;
    assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
    assign w_beat_err   = (bus.M_AXI_RRESP != 2'b00) || (bus.M_AXI_RLAST != w_last_beat);
    // A frame_start coinciding with the request makes this line 0.
    assign w_req_idx    = bus.frame_start ? '0 : r_line_idx;
    assign w_frame_base = {bus.frame_base[AW-1:12], 12'h000};
    assign w_req_base   = (w_req_idx == '0) ? w_frame_base : r_base;
    assign w_line_off   = AW'(w_req_idx) * AW'(LINE_BYTES);
    assign w_unused     = ^bus.frame_base[11:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_arvalid_nxt   = r_arvalid;
        w_araddr_nxt    = r_araddr;
        w_err_nxt       = r_err;
        w_line_idx_nxt  = r_line_idx;
        w_base_nxt      = r_base;
        w_burst_cnt_nxt = r_burst_cnt;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_fs_pend_nxt   = r_fs_pend;
        w_wr_en_nxt     = w_beat;
        w_wr_data_nxt   = w_beat ? bus.M_AXI_RDATA : r_wr_data;

        if (bus.frame_start && (r_state != StIdle)) begin
            w_fs_pend_nxt = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (bus.frame_start) begin
                    w_line_idx_nxt = '0;
                    w_fs_pend_nxt  = 1'b0;
                end
                if (w_req) begin
                    w_base_nxt      = w_req_base;
                    w_araddr_nxt    = w_req_base + w_line_off;
                    w_burst_cnt_nxt = '0;
                    w_state_nxt     = StGap;
                end
            end
            StGap: begin
                if (!bus.fifo_prog_full) begin
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = StAddr;
                end
            end
            StAddr: begin
                if (bus.M_AXI_ARREADY) begin
                    w_arvalid_nxt  = 1'b0;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = StData;
                end
            end
            StData: begin
                if (w_beat) begin
                    if (w_beat_err) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_beat_cnt_nxt = '0;
                        if (r_burst_cnt == LAST_BURST) begin
                            w_state_nxt    = StIdle;
                            w_fs_pend_nxt  = 1'b0;
                            w_line_idx_nxt = (r_fs_pend || bus.frame_start ||
                                              (r_line_idx == LAST_LINE)) ? '0 :
                                             r_line_idx + LINE_W'(1);
                        end else begin
                            w_araddr_nxt    = r_araddr + AW'(BURST_BYTES);
                            w_burst_cnt_nxt = r_burst_cnt + BURST_W'(1);
                            w_state_nxt     = StGap;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_ready_nxt = (w_state_nxt == StIdle);
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state     <= StIdle;
            r_ready     <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_err       <= 1'b0;
            r_line_idx  <= '0;
            r_base      <= '0;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_fs_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= w_ready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_araddr    <= w_araddr_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_err       <= w_err_nxt;
            r_line_idx  <= w_line_idx_nxt;
            r_base      <= w_base_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_fs_pend   <= w_fs_pend_nxt;
        end
    end

    assign bus.AXI_FULL_BURST_READY = r_ready;
    assign bus.M_AXI_ARADDR         = r_araddr;
    assign bus.M_AXI_ARLEN          = 8'(BURST_LEN - 1);
    assign bus.M_AXI_ARSIZE         = 3'($clog2(BEAT_BYTES));
    assign bus.M_AXI_ARBURST        = 2'b01;
    assign bus.M_AXI_ARVALID        = r_arvalid;
    assign bus.M_AXI_RREADY         = (r_state == StData);
    assign bus.fifo_wr_en           = r_wr_en;
    assign bus.fifo_wr_data         = r_wr_data;
    assign bus.rd_err               = r_err;
endmodule

// File: tb/tb_ddr_line_reader.sv
// Bench for ddr_line_reader: zero-wait AXI read slave with knobs for stalls and faulty
// responses, plus address and data scoreboards. Uses a 6-line frame to keep runs short.
module tb_ddr_line_reader;
    localparam int unsigned DW   = 128;
    localparam int unsigned AW   = 32;
    localparam int unsigned VD   = 6;
    localparam int unsigned NBUR = 30;
    localparam int unsigned LB   = 7680;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr_line_reader_if #(.AXI4_DATA_WIDTH(DW), .AXI4_ADDR_WIDTH(AW)) bus ();

    ddr_line_reader #(
        .AXI4_DATA_WIDTH(DW),
        .AXI4_ADDR_WIDTH(AW),
        .H_DISP         (1920),
        .V_DISP         (VD),
        .BURST_LEN      (16)
    ) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] data_q[$];
    int wr_count = 0;
    int ar_count = 0;
    int ar_stall_left = 0;
    logic resp_err = 1'b0;
    logic rlast_early = 1'b0;

    int m_idx = 0;
    int m_cur = 0;
    logic [AW-1:0] m_base = '0;
    int w0 = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI read slave and output monitors, all evaluated on the falling edge.
    initial begin
        int beats_left;
        int beat_idx;
        logic prev_arv;
        logic prev_pf;
        logic stall_pend;
        logic [AW-1:0] stall_addr;
        beats_left = 0;
        beat_idx   = 0;
        prev_arv   = 1'b0;
        prev_pf    = 1'b0;
        stall_pend = 1'b0;
        stall_addr = '0;
        bus.M_AXI_ARREADY = 1'b0;
        bus.M_AXI_RVALID  = 1'b0;
        bus.M_AXI_RDATA   = '0;
        bus.M_AXI_RRESP   = 2'b00;
        bus.M_AXI_RLAST   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats_left = 0;
                prev_arv   = 1'b0;
                stall_pend = 1'b0;
                bus.M_AXI_ARREADY = 1'b0;
                bus.M_AXI_RVALID  = 1'b0;
                bus.M_AXI_RLAST   = 1'b0;
                bus.M_AXI_RRESP   = 2'b00;
                continue;
            end
            if (bus.fifo_wr_en) begin
                wr_count++;
                if (data_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_data", bus.fifo_wr_data, data_q.pop_front());
            end
            if (stall_pend) begin
                chk("ar_hold_valid", bus.M_AXI_ARVALID, 1);
                chk("ar_hold_addr", bus.M_AXI_ARADDR, stall_addr);
            end
            if (bus.M_AXI_ARVALID && !prev_arv) chk("ar_vs_prog_full", prev_pf, 0);
            prev_arv = bus.M_AXI_ARVALID;
            prev_pf  = bus.fifo_prog_full;

            bus.M_AXI_ARREADY = (ar_stall_left == 0);
            if (bus.M_AXI_ARVALID && ar_stall_left > 0) ar_stall_left--;
            if (beats_left > 0) begin
                bus.M_AXI_RVALID = 1'b1;
                bus.M_AXI_RDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.M_AXI_RRESP  = resp_err ? 2'b10 : 2'b00;
                bus.M_AXI_RLAST  = (beat_idx == 15) || (rlast_early && beat_idx == 7);
            end else begin
                bus.M_AXI_RVALID = 1'b0;
                bus.M_AXI_RLAST  = 1'b0;
                bus.M_AXI_RRESP  = 2'b00;
            end

            // Handshakes that will complete on the coming rising edge.
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
                data_q.push_back(bus.M_AXI_RDATA);
                if (bus.M_AXI_RRESP != 2'b00) resp_err = 1'b0;
                if (rlast_early && beat_idx == 7) rlast_early = 1'b0;
                beat_idx++;
                beats_left--;
            end
            stall_pend = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
            stall_addr = bus.M_AXI_ARADDR;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                ar_count++;
                if (addr_q.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("ar_addr", bus.M_AXI_ARADDR, addr_q.pop_front());
                chk("ar_len", bus.M_AXI_ARLEN, 15);
                chk("ar_size", bus.M_AXI_ARSIZE, 4);
                chk("ar_burst", bus.M_AXI_ARBURST, 1);
                beats_left = 16;
                beat_idx   = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.AXI_FULL_BURST_READY && n < 3000) begin
            step();
            n++;
        end
        if (!bus.AXI_FULL_BURST_READY) chk(tag, 0, 1);
    endtask

    task automatic start_line(input logic fs);
        wait_ready("ready_before_req");
        m_cur = fs ? 0 : m_idx;
        if (m_cur == 0) m_base = bus.frame_base & 32'hFFFF_F000;
        for (int b = 0; b < NBUR; b++) begin
            addr_q.push_back(m_base + AW'(m_cur) * LB + AW'(b) * 256);
        end
        w0 = wr_count;
        bus.AXI_FULL_BURST_VALID = 1'b1;
        bus.frame_start = fs;
        step();
        bus.AXI_FULL_BURST_VALID = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic finish_line(input logic fs_pend);
        wait_ready("line_timeout");
        step();
        chk("line_writes", wr_count - w0, 480);
        chk("line_ar_left", addr_q.size(), 0);
        m_idx = (fs_pend || m_cur == VD - 1) ? 0 : m_cur + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        addr_q.delete();
        data_q.delete();
        step();
        rst = 1'b0;
        step();
        m_idx = 0;
    endtask

    initial begin
        int n;
        int a0;
        int highs;
        bus.AXI_FULL_BURST_VALID = 1'b0;
        bus.frame_start    = 1'b0;
        bus.frame_base     = 32'h1000_0000;
        bus.fifo_prog_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.AXI_FULL_BURST_READY, 0);
        chk("rst_arvalid", bus.M_AXI_ARVALID, 0);
        chk("rst_araddr", bus.M_AXI_ARADDR, 0);
        chk("rst_rready", bus.M_AXI_RREADY, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_wr_data", bus.fifo_wr_data, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        rst = 1'b0;
        chk("ready_before_edge", bus.AXI_FULL_BURST_READY, 0);
        step();
        chk("ready_after_release", bus.AXI_FULL_BURST_READY, 1);

        // Line 0 with request-to-AR latency check.
        start_line(1'b0);
        chk("ready_drop", bus.AXI_FULL_BURST_READY, 0);
        step();
        chk("arvalid_at_n2", bus.M_AXI_ARVALID, 1);
        finish_line(1'b0);
        chk("rd_err_clean", bus.rd_err, 0);

        // Rest of the frame; base change mid-frame only applies at the wrap.
        for (int l = 1; l < VD; l++) begin
            if (l == 3) bus.frame_base = 32'h2000_0ABC;
            start_line(1'b0);
            finish_line(1'b0);
        end
        start_line(1'b0);
        chk("wrap_line0", m_cur, 0);
        finish_line(1'b0);

        // frame_start during a fetch: line completes, next request is line 0.
        start_line(1'b0);
        repeat (100) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        finish_line(1'b1);
        start_line(1'b0);
        finish_line(1'b0);
        // frame_start coincident with the request, then alone in IDLE.
        start_line(1'b1);
        finish_line(1'b0);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        m_idx = 0;
        start_line(1'b0);
        finish_line(1'b0);

        // prog_full held for 50 cycles after the third burst address.
        start_line(1'b0);
        a0 = ar_count;
        n = 0;
        while (ar_count < a0 + 3 && n < 2000) begin
            step();
            n++;
        end
        chk("pf_third_ar_seen", ar_count - a0, 3);
        bus.fifo_prog_full = 1'b1;
        highs = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.M_AXI_ARVALID) highs++;
        end
        chk("pf_no_arvalid", highs, 0);
        bus.fifo_prog_full = 1'b0;
        n = 0;
        while (!bus.M_AXI_ARVALID && n < 4) begin
            step();
            n++;
        end
        chk("pf_ar_latency_ok", (n >= 1 && n <= 2), 1);
        finish_line(1'b0);

        // Error response, then sticky across a clean line.
        resp_err = 1'b1;
        start_line(1'b0);
        finish_line(1'b0);
        chk("rresp_err", bus.rd_err, 1);
        start_line(1'b0);
        finish_line(1'b0);
        chk("rresp_err_sticky", bus.rd_err, 1);
        do_reset();
        chk("err_cleared", bus.rd_err, 0);
        rlast_early = 1'b1;
        start_line(1'b0);
        finish_line(1'b0);
        chk("rlast_early_err", bus.rd_err, 1);

        // ARREADY stall then reset mid-DATA.
        do_reset();
        ar_stall_left = 20;
        start_line(1'b0);
        n = 0;
        while (!(bus.M_AXI_RREADY && bus.fifo_wr_en) && n < 200) begin
            step();
            n++;
        end
        chk("stall_reached_data", bus.M_AXI_RREADY && bus.fifo_wr_en, 1);
        rst = 1'b1;
        addr_q.delete();
        data_q.delete();
        #1;
        chk("mid_rst_arvalid", bus.M_AXI_ARVALID, 0);
        chk("mid_rst_rready", bus.M_AXI_RREADY, 0);
        chk("mid_rst_wr_en", bus.fifo_wr_en, 0);
        chk("mid_rst_ready", bus.AXI_FULL_BURST_READY, 0);
        step();
        step();
        rst = 1'b0;
        chk("rel_ready_before", bus.AXI_FULL_BURST_READY, 0);
        step();
        chk("rel_ready_after", bus.AXI_FULL_BURST_READY, 1);
        repeat (5) step();
        chk("no_writes_after_rst", data_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end
endmodule
